// File: rtl/tx_link_fsm.sv
// tx_link_fsm: JESD204B TX link-layer sequencer, CGS -> ILAS -> DATA.
// Define TX_LINK_ILAS_EN to build the ILAS phase; otherwise CGS goes straight to DATA.
module tx_link_fsm #(
   parameter int ILAS_MF    = 4,
   parameter int RESYNC_CYC = 16
) (
   input  logic       CLK,
   input  logic       RST_n,
   input  logic       EN,
   input  logic       SYNC_n,
   input  logic       LMFC_SYNCED,
   input  logic       LMFC_END,
   input  logic       ERR_CLR,
   output logic       LOAD_SETUP,
   output logic [2:0] STATE,
   output logic       CGS_ACT,
   output logic       ILAS_ACT,
   output logic [2:0] ILAS_IDX,
   output logic       ILAS_CFG,
   output logic       LINK_UP,
   output logic [7:0] ERR_CNT
);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      WAIT_LMFC = 3'd1,
      CGS       = 3'd2,
      ILAS      = 3'd3,
      DATA      = 3'd4
   } state_t;

   localparam logic [7:0] RESYNC_TH = 8'(RESYNC_CYC);

   logic       sync_m_q;
   logic       sync_s_q;
   state_t     state_q,  state_d;
   logic [7:0] run_q,    run_d;
   logic [7:0] err_q,    err_d;
   logic       load_q,   load_d;
   logic       cgs_q,    cgs_d;
   logic       up_q,     up_d;
   logic [7:0] run_inc;
   logic       run_on;
   logic       low_end;
   logic       resync;

`ifdef TX_LINK_ILAS_EN
   localparam logic [2:0] ILAS_LAST = 3'(ILAS_MF - 1);

   logic       ilas_q,     ilas_d;
   logic [2:0] ilas_idx_q, ilas_idx_d;
   logic       cfg_q,      cfg_d;
`else
   logic unused_ilas_mf;
   assign unused_ilas_mf = (ILAS_MF != 0);
`endif

   // Next-state, low-run tracking, error count and registered output values
   always_comb begin
      state_d = state_q;
      run_d   = 8'd0;
      err_d   = err_q;
      low_end = 1'b0;
      resync  = 1'b0;
      run_inc = (run_q == 8'hFF) ? run_q : run_q + 8'd1;
`ifdef TX_LINK_ILAS_EN
      ilas_idx_d = ilas_idx_q;
      run_on     = (state_q == ILAS) || (state_q == DATA);
`else
      run_on     = (state_q == DATA);
`endif

      if (run_on) begin
         if (!sync_s_q) begin
            if (run_inc == RESYNC_TH) begin
               resync = 1'b1;
            end else begin
               run_d = run_inc;
            end
         end else begin
            low_end = (state_q == DATA) && (run_q != 8'd0);
         end
      end

      unique case (state_q)
         IDLE: begin
            if (EN) state_d = WAIT_LMFC;
         end
         WAIT_LMFC: begin
            if (LMFC_SYNCED) state_d = CGS;
         end
         CGS: begin
            if (LMFC_END && sync_s_q) begin
`ifdef TX_LINK_ILAS_EN
               state_d = ILAS;
`else
               state_d = DATA;
`endif
            end
         end
`ifdef TX_LINK_ILAS_EN
         ILAS: begin
            if (resync) begin
               state_d = CGS;
            end else if (LMFC_END) begin
               if (ilas_idx_q == ILAS_LAST) begin
                  state_d = DATA;
               end else begin
                  ilas_idx_d = ilas_idx_q + 3'd1;
               end
            end
         end
`endif
         DATA: begin
            if (resync) state_d = CGS;
         end
         default: state_d = IDLE;
      endcase

      if (!EN) begin
         state_d = IDLE;
         run_d   = 8'd0;
      end

`ifdef TX_LINK_ILAS_EN
      if (state_d != ILAS) ilas_idx_d = 3'd0;
      ilas_d = (state_d == ILAS);
      cfg_d  = (state_d == ILAS) && (ilas_idx_d == 3'd1);
`endif

      if (low_end && (err_q != 8'hFF)) err_d = err_q + 8'd1;
      if (ERR_CLR) err_d = 8'd0;

      load_d = (state_q == IDLE) && (state_d == WAIT_LMFC);
      cgs_d  = (state_d == CGS);
      up_d   = (state_d == DATA);
   end

   // SYNC~ synchronizer, FSM state and all registered outputs
   always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n) begin
         sync_m_q   <= 1'b0;
         sync_s_q   <= 1'b0;
         state_q    <= IDLE;
         run_q      <= 8'd0;
         err_q      <= 8'd0;
         load_q     <= 1'b0;
         cgs_q      <= 1'b0;
         up_q       <= 1'b0;
`ifdef TX_LINK_ILAS_EN
         ilas_q     <= 1'b0;
         ilas_idx_q <= 3'd0;
         cfg_q      <= 1'b0;
`endif
      end else begin
         sync_m_q   <= SYNC_n;
         sync_s_q   <= sync_m_q;
         state_q    <= state_d;
         run_q      <= run_d;
         err_q      <= err_d;
         load_q     <= load_d;
         cgs_q      <= cgs_d;
         up_q       <= up_d;
`ifdef TX_LINK_ILAS_EN
         ilas_q     <= ilas_d;
         ilas_idx_q <= ilas_idx_d;
         cfg_q      <= cfg_d;
`endif
      end
   end

   assign LOAD_SETUP = load_q;
   assign STATE      = state_q;
   assign CGS_ACT    = cgs_q;
   assign LINK_UP    = up_q;
   assign ERR_CNT    = err_q;
`ifdef TX_LINK_ILAS_EN
   assign ILAS_ACT   = ilas_q;
   assign ILAS_IDX   = ilas_idx_q;
   assign ILAS_CFG   = cfg_q;
`else
   assign ILAS_ACT   = 1'b0;
   assign ILAS_IDX   = 3'd0;
   assign ILAS_CFG   = 1'b0;
`endif

endmodule
